// File: rtl/uart_tx_fifo_if.sv
// Byte-push handshake plus serial/status outputs of uart_tx_fifo.
// master drives bytes in; slave is the transmitter.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          tx;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, busy, fifo_count
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, busy, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter behind a byte FIFO; the first start bit reaches tx 2 clocks after a push into an idle block.
// tx_ready drops while the FIFO is full; queued bytes go out back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  uart_tx_fifo_if.slave s_if
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cyc;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [NW-1:0]   r_count;

  logic w_ready;
  logic w_push;
  logic w_not_empty;
  logic w_bit_end;
  logic w_pop;

  assign w_ready     = (r_count < NW'(FIFO_DEPTH));
  assign w_push      = s_if.tx_valid && w_ready;
  assign w_not_empty = (r_count != '0);
  assign w_bit_end   = (r_cyc == LAST_CYC);
  // A byte pushed into an empty FIFO is only visible to the pop on the following edge.
  assign w_pop       = w_not_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  assign s_if.tx_ready   = w_ready;
  assign s_if.tx         = r_tx;
  assign s_if.busy       = (r_state != IDLE);
  assign s_if.fifo_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= s_if.tx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + NW'(w_push) - NW'(w_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      // tx trails the state by one clock so every bit lasts exactly BIT_CYCLES.
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_cyc   <= '0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_bit   <= '0;
            r_state <= DATA;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cyc   <= '0;
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timeline model predicts tx/busy/fifo_count/tx_ready every cycle,
// and a line receiver decodes tx into bytes compared with hand-written lists.
module tb_uart_tx_fifo;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 10_000_000;
  localparam int B        = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 10 * B;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  uart_tx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .s_if   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: queue of waiting bytes plus the offset into the current 10-bit frame.
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_s      = 0;
  logic [7:0] m_byte   = 8'h00;
  logic       m_tx     = 1'b1;

  function automatic logic frame_bit(input logic [7:0] b, input int s);
    int k;
    k = s / B;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_s      = 0;
      m_tx     = 1'b1;
    end else begin
      bit room;
      bit pop;
      room = (m_q.size() < DEPTH);
      m_tx = m_active ? frame_bit(m_byte, m_s) : 1'b1;
      pop  = (!m_active || m_s == FRAME - 1) && (m_q.size() != 0);
      if (pop) begin
        m_byte   = m_q.pop_front();
        m_s      = 0;
        m_active = 1'b1;
      end else if (m_active) begin
        if (m_s == FRAME - 1) m_active = 1'b0;
        else m_s++;
      end
      if (ifc.tx_valid && room) m_q.push_back(ifc.tx_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("tx", ifc.tx, m_tx);
      chk("busy", ifc.busy, m_active);
      chk("fifo_count", ifc.fifo_count, m_q.size());
      chk("tx_ready", ifc.tx_ready, m_q.size() < DEPTH);
    end
  end

  // Line receiver: samples mid-bit, records every falling edge of tx.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         falls[$];
  logic       rx_prev = 1'b1;
  bit         rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_sh   = 8'h00;

  always @(negedge clk) begin : rx_model
    int k;
    if (!rst_n) begin
      rx_busy = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (rx_prev && !ifc.tx) falls.push_back(cyc);
      rx_prev = ifc.tx;
      if (!rx_busy) begin
        if (!ifc.tx) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % B == B / 2) begin
          k = rx_cnt / B;
          if (k == 0) begin
            if (ifc.tx) rx_busy = 1'b0;
          end else if (k <= 8) begin
            rx_sh[k-1] = ifc.tx;
          end else begin
            chk("stop_bit", ifc.tx, 1);
            rx_q.push_back(rx_sh);
            rx_busy = 1'b0;
          end
        end
      end
    end
  end

  function automatic bit has_fall(input int c);
    foreach (falls[i]) if (falls[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send(input logic [7:0] d, output int edge_cyc);
    ifc.tx_data  = d;
    ifc.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.tx_valid = 1'b0;
    edge_cyc     = cyc;
  endtask

  task automatic send_thr(input logic [7:0] d);
    int n;
    int e;
    n = 0;
    while (!ifc.tx_ready && n < 2 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("thr_ready_wait", ifc.tx_ready, 1);
    send(d, e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((ifc.busy || ifc.fifo_count != 0) && n < 20 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_idle_busy"}, ifc.busy, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_rx(input string name);
    chk({name, "_rx_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({name, "_rx_byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    falls.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int t0;
    int t;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_tx", ifc.tx, 1);
    chk("reset_busy", ifc.busy, 0);
    chk("reset_count", ifc.fifo_count, 0);
    chk("reset_ready", ifc.tx_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x41: start low 2 clocks after push, bit1 falls 2 bits after start.
    send(8'h41, t0);
    wait_idle("single");
    chk("single_start_delay", (falls.size() > 0) ? falls[0] - t0 : -1, 2);
    chk("single_bit1_fall", (falls.size() > 1) ? falls[1] - falls[0] : -1, 2 * B);
    exp_q.push_back(8'h41);
    chk_rx("single");

    // "HI\r" on consecutive cycles.
    chk("str_ready0", ifc.tx_ready, 1);
    send(8'h48, t0);
    chk("str_ready1", ifc.tx_ready, 1);
    send(8'h49, t);
    chk("str_ready2", ifc.tx_ready, 1);
    send(8'h0D, t);
    chk("str_count_peak", ifc.fifo_count, 2);
    wait_idle("str");
    for (int k = 0; k < 3; k++) chk("str_frame_start", has_fall(t0 + 2 + k * FRAME), 1);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    exp_q.push_back(8'h0D);
    chk_rx("str");

    // Overflow: 0x06 arrives while full and is dropped.
    for (int i = 1; i <= 5; i++) send(8'(i), t);
    chk("ovf_ready_full", ifc.tx_ready, 0);
    chk("ovf_count_full", ifc.fifo_count, 4);
    send(8'h06, t);
    chk("ovf_count_after_drop", ifc.fifo_count, 4);
    wait_idle("ovf");
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    chk_rx("ovf");

    // Pointer wrap-around with throttled pushes.
    for (int i = 0; i < 10; i++) send_thr(8'(8'h30 + i));
    wait_idle("wrap");
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(8'h30 + i));
    chk_rx("wrap");

    // Reset while shifting data bit 3 of 0xFF.
    send(8'hFF, t0);
    repeat (1 + 4 * B + 2) @(posedge clk);
    #1;
    chk("rst_pre_busy", ifc.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", ifc.tx, 1);
    chk("rst_mid_busy", ifc.busy, 0);
    chk("rst_mid_count", ifc.fifo_count, 0);
    chk("rst_mid_ready", ifc.tx_ready, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("rst_hold_tx", ifc.tx, 1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after_tx", ifc.tx, 1);
    chk("rst_after_count", ifc.fifo_count, 0);
    falls.delete();
    rx_q.delete();
    send(8'h55, t0);
    wait_idle("rst");
    chk("rst_first_fall", (falls.size() > 0) ? falls[0] - t0 : -1, 2);
    exp_q.push_back(8'h55);
    chk_rx("rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Synthesizable 8N1 UART transmitter with a small byte FIFO on its input.
- Sits in the DUT directly upstream of the bench UART model; its serial output drives the model's RX pin.
- The model prints a line once it sees CR (0x0D) or LF (0x0A).
- Core logic loads bytes over a valid/ready handshake; the block frames and shifts them out LSB-first at a fixed baud.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- BIT_CYCLES, CLK_FREQ/BAUD (integer division, 868 at defaults), clocks per serial bit.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte (count < FIFO_DEPTH).
- tx  out  1  serial line, registered; idle high.
- busy  out  1  high while a frame is in progress (state != IDLE).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, busy=0, fifo_count=0, tx_ready=1.
  - State=IDLE; bit counter, cycle counter, shift register and FIFO pointers cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high with no stop bit, and queued bytes are discarded.
- Push:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_ready is combinational from fifo_count only; it does not look ahead to a same-cycle pop.
  - When full, tx_valid is ignored, nothing is written and the data is lost upstream's responsibility.
- Pop: occurs only on an IDLE→START or STOP→START transition.
- Simultaneous push and pop (FIFO not full): both happen and fifo_count is unchanged. On an empty FIFO no pop can occur that cycle; the pushed byte is popped on the next edge.
- FIFO storage: circular buffer. Read/write pointers wrap modulo FIFO_DEPTH; full/empty are derived from fifo_count.
- State machine:
  - IDLE: tx=1. If fifo_count>0: pop head into shift register, cycle counter=0, go to START.
  - START: tx=0 for BIT_CYCLES clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BIT_CYCLES clocks, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for BIT_CYCLES clocks. At the end, if fifo_count>0 pop and go to START (back-to-back, no idle gap); otherwise go to IDLE.
- Timing:
  - tx is driven from a registered version of the state/shift LSB.
  - The first start-bit edge appears on tx exactly 2 clocks after the pushing edge into an empty IDLE block: push edge, pop edge, then tx register.
  - Every bit, including stop, lasts exactly BIT_CYCLES clocks.
  - Frame = 10*BIT_CYCLES clocks; back-to-back frames have period exactly 10*BIT_CYCLES.
- Counters:
  - Cycle counter width = $clog2(BIT_CYCLES); it counts 0..BIT_CYCLES-1 and wraps.
  - Bit index is 3 bits.
  - No counter ever exceeds its terminal value.
- busy: rises on the same edge as the IDLE→START transition and falls on the STOP→IDLE edge. It stays high across back-to-back frames.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation at any state → tx=1, busy=0, fifo_count=0, tx_ready=1 with no clock edge required.
- Single byte: push 0x41 at 100 MHz, model at baud 115200 (bittime 8680 ns) → the model's evByte fires once with rxData=0x41. tx low for exactly 868 clocks starting 2 clocks after push, then bits 1,0,0,0,0,0,1,0, then stop high for 868 clocks, then busy=0.
- String: push "HI\r" (0x48,0x49,0x0D) in 3 consecutive cycles → tx_ready stays 1, fifo_count peaks at 2. Frames are back-to-back with falling start edges exactly 8680 clocks apart; the model displays buffer ending 0x4849.
- Overflow: with a frame in progress, push 6 bytes 0x01..0x06 on consecutive cycles → 0x01 becomes the shifting byte, 0x02..0x05 fill the FIFO, tx_ready=0 and 0x06 is dropped. The model receives exactly 0x01..0x05 in order.
- FIFO wrap-around: push 10 bytes 0x30..0x39 throttled on tx_ready → all 10 received in order, confirming pointers wrap correctly past FIFO_DEPTH.
- Reset mid-frame: push 0xFF, assert rst_n low during the DATA state at bit index 3 for 5 clocks, release, then push 0x55 → tx high during and after reset, FIFO empty. The next falling edge is the 0x55 start bit, and the model's final evByte reports 0x55.
